vend_datapath_p: RTL and testbench
==================================

Name: vend_datapath_p

Overview:
Parametrised next-generation vending-machine data path. Holds a configurable item table (price and quantity per slot) and accumulates coin/note credit up to a ceiling. It vends through a two-cycle select/commit sequence and returns change, refunds or rejected payments. It sits between the payment/keypad front end and the vending control unit, and also exposes a table-load port for restocking.

Parameters:
N_ITEMS, 32, number of item slots (≥2)
SEL_W, 5, slot index width; 2^SEL_W ≥ N_ITEMS
MONEY_W, 13, width of payment, credit and change
PRICE_W, 10, per-item price width; PRICE_W ≤ MONEY_W
QTY_W, 5, per-item quantity width
MAX_CREDIT, 5000, credit ceiling; must be < 2^MONEY_W

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
pay_valid  in  1  payment strobe, one coin/note per cycle
payment  in  MONEY_W  value of the payment
sel_valid  in  1  selection strobe
select  in  SEL_W  requested slot
cancel  in  1  abort transaction, refund credit
cfg_we  in  1  table write strobe
cfg_addr  in  SEL_W  slot to write
cfg_price  in  PRICE_W  new price
cfg_qty  in  QTY_W  new quantity
credit  out  MONEY_W  current accumulated credit
avail  out  N_ITEMS  bit i = qty[i]>0 and credit≥price[i]
busy  out  1  high in VEND
deposit  out  1  one-cycle pulse, item dispensed
drop  out  SEL_W  slot dispensed; valid with deposit
change_valid  out  1  one-cycle pulse, change/refund value valid
change  out  MONEY_W  change or refund amount
reject  out  1  one-cycle pulse, payment returned unaccepted
err_sold_out  out  1  one-cycle pulse, selected slot empty
err_funds  out  1  one-cycle pulse, credit < price
cfg_ack  out  1  one-cycle pulse, table write accepted

Behaviour:
- All state is registered on the clk rising edge. rst is sampled only at the clock edge.
- Reset effects: state=IDLE; credit=0; all table entries price=0 and qty=0; all pulse outputs 0; drop=0; change=0.
- Pulse outputs default to 0 every cycle unless set below. change and drop hold their last value.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0.
  - VEND: one cycle; uses the latched slot index sel_q.
- Priority in IDLE/COLLECT: cancel > sel_valid > pay_valid. Only the highest-priority request is acted on. A lower-priority pay_valid in that cycle is rejected (reject=1). A lower-priority sel_valid is dropped with no response.
- Payment:
  - If credit+payment ≤ MAX_CREDIT (sum computed at MONEY_W+1 bits), credit += payment and the state moves to COLLECT when the new credit is >0.
  - Otherwise credit is unchanged and reject=1 next cycle.
  - payment==0 with pay_valid has no effect.
- Cancel:
  - In COLLECT: change=credit, change_valid=1, credit=0, go to IDLE.
  - In IDLE: no effect.
- Select:
  - In COLLECT: latch sel_q=select and go to VEND.
  - In IDLE: sel_valid is ignored.
  - select ≥ N_ITEMS is treated as sold out.
- VEND (pay_valid in this cycle is rejected; cancel and sel_valid are ignored):
  - qty[sel_q]==0 or sel_q out of range: err_sold_out=1, return to COLLECT, credit unchanged.
  - Else credit<price[sel_q]: err_funds=1, return to COLLECT.
  - Else: deposit=1; drop=sel_q; qty[sel_q]-=1; change=credit−price[sel_q]; change_valid=1 (also when change is 0); credit=0; go to IDLE.
  - Latency: the sel_valid edge leads, 2 edges later, to deposit/change_valid asserted.
- Table writes:
  - Accepted only in IDLE, with cfg_addr < N_ITEMS. The write updates price and qty, and cfg_ack=1 next cycle.
  - Writes in any other state, or to an out-of-range cfg_addr, are dropped with no cfg_ack.
  - A write in IDLE does not conflict with payment processing in the same cycle; both take effect.
- avail is combinational from the registered credit and table; it is all-zero when credit==0 unless a slot has price 0 and qty>0.
- Quantity never wraps: decrement happens only when qty>0.
- rst asserted in any state, including VEND, aborts the transaction with no deposit or change pulse. Credit is lost by design.

Test Plan:
- Reset, load slot 3 (price 150, qty 2, cfg_ack=1), pay 100 then 100, select 3 -> credit=200; 2 edges after sel_valid: deposit=1, drop=3, change=50, change_valid=1, credit=0, qty[3]=1.
- Slot 3 qty 1, vend twice with exact 150 -> first: deposit=1, change=0, change_valid=1; second: err_sold_out=1, credit stays 150, state COLLECT; cancel -> change=150, change_valid=1.
- Credit 4900, pay 200 -> reject=1, credit=4900; pay 100 -> credit=5000; pay 1 -> reject=1.
- Credit 100, select slot priced 150 -> err_funds=1, credit=100; pay 50, reselect -> deposit=1, change=0.
- Same cycle: cancel+sel_valid+pay_valid with credit 70 (pay 20) -> change=70, reject=1, no VEND; cfg_we in COLLECT -> no cfg_ack, table unchanged.
- rst asserted during VEND -> next cycle credit=0, deposit=0, change_valid=0, all table qty=0.

Source files
------------

// File: rtl/vend_datapath_p.sv
// Vending-machine data path: slot table (price/qty), credit accumulator with
// a ceiling, two-cycle select/commit vend, and change/refund/reject returns.
module vend_datapath_p #(
   parameter int N_ITEMS    = 32,
   parameter int SEL_W      = 5,
   parameter int MONEY_W    = 13,
   parameter int PRICE_W    = 10,
   parameter int QTY_W      = 5,
   parameter int MAX_CREDIT = 5000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pay_valid,
   input  logic [MONEY_W-1:0] payment,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   select,
   input  logic               cancel,
   input  logic               cfg_we,
   input  logic [SEL_W-1:0]   cfg_addr,
   input  logic [PRICE_W-1:0] cfg_price,
   input  logic [QTY_W-1:0]   cfg_qty,
   output logic [MONEY_W-1:0] credit,
   output logic [N_ITEMS-1:0] avail,
   output logic               busy,
   output logic               deposit,
   output logic [SEL_W-1:0]   drop,
   output logic               change_valid,
   output logic [MONEY_W-1:0] change,
   output logic               reject,
   output logic               err_sold_out,
   output logic               err_funds,
   output logic               cfg_ack
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND} state_t;

   state_t             state_q, state_d;
   logic [MONEY_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [PRICE_W-1:0] price_q [N_ITEMS];
   logic [QTY_W-1:0]   qty_q   [N_ITEMS];
   logic [MONEY_W-1:0] change_q, change_d;
   logic [SEL_W-1:0]   drop_q, drop_d;
   logic               deposit_q, deposit_d, cv_q, cv_d, reject_q, reject_d;
   logic               sold_q, sold_d, funds_q, funds_d, ack_q, ack_d;

   logic [MONEY_W:0]   sum;
   logic               sel_ok, wr, dec;
   logic [SEL_W-1:0]   sel_idx;
   logic [PRICE_W-1:0] sel_price;
   logic [QTY_W-1:0]   sel_qty;

   // Latched slot lookup; out-of-range slots read slot 0 but are treated as sold out.
   assign sel_ok    = int'(sel_q) < N_ITEMS;
   assign sel_idx   = sel_ok ? sel_q : '0;
   assign sel_price = price_q[sel_idx];
   assign sel_qty   = qty_q[sel_idx];
   assign sum       = {1'b0, credit_q} + {1'b0, payment};

   // Next-state and pulse decode; cancel > select > payment in IDLE/COLLECT.
   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      sel_d     = sel_q;
      change_d  = change_q;
      drop_d    = drop_q;
      deposit_d = 1'b0;
      cv_d      = 1'b0;
      reject_d  = 1'b0;
      sold_d    = 1'b0;
      funds_d   = 1'b0;
      ack_d     = 1'b0;
      wr        = 1'b0;
      dec       = 1'b0;
      case (state_q)
         IDLE, COLLECT: begin
            wr    = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < N_ITEMS);
            ack_d = wr;
            if (cancel) begin
               reject_d = pay_valid;
               if (state_q == COLLECT) begin
                  change_d = credit_q;
                  cv_d     = 1'b1;
                  credit_d = '0;
                  state_d  = IDLE;
               end
            end else if (sel_valid) begin
               reject_d = pay_valid;
               if (state_q == COLLECT) begin
                  sel_d   = select;
                  state_d = VEND;
               end
            end else if (pay_valid && (payment != '0)) begin
               if (sum <= (MONEY_W+1)'(MAX_CREDIT)) begin
                  credit_d = sum[MONEY_W-1:0];
                  state_d  = COLLECT;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         VEND: begin
            reject_d = pay_valid;
            if (!sel_ok || (sel_qty == '0)) begin
               sold_d  = 1'b1;
               state_d = COLLECT;
            end else if (credit_q < MONEY_W'(sel_price)) begin
               funds_d = 1'b1;
               state_d = COLLECT;
            end else begin
               deposit_d = 1'b1;
               drop_d    = sel_q;
               dec       = 1'b1;
               change_d  = credit_q - MONEY_W'(sel_price);
               cv_d      = 1'b1;
               credit_d  = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control, credit and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         credit_q  <= '0;
         sel_q     <= '0;
         change_q  <= '0;
         drop_q    <= '0;
         deposit_q <= 1'b0;
         cv_q      <= 1'b0;
         reject_q  <= 1'b0;
         sold_q    <= 1'b0;
         funds_q   <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         sel_q     <= sel_d;
         change_q  <= change_d;
         drop_q    <= drop_d;
         deposit_q <= deposit_d;
         cv_q      <= cv_d;
         reject_q  <= reject_d;
         sold_q    <= sold_d;
         funds_q   <= funds_d;
         ack_q     <= ack_d;
      end
   end

   // Slot table: restock writes (IDLE only) and vend decrements never coincide.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_ITEMS; i++) begin
         if (rst) begin
            price_q[i] <= '0;
            qty_q[i]   <= '0;
         end else if (wr && (int'(cfg_addr) == i)) begin
            price_q[i] <= cfg_price;
            qty_q[i]   <= cfg_qty;
         end else if (dec && (int'(sel_q) == i)) begin
            qty_q[i]   <= qty_q[i] - QTY_W'(1);
         end
      end
   end

   // Per-slot availability from registered credit and table.
   for (genvar g = 0; g < N_ITEMS; g++) begin : g_avail
      assign avail[g] = (qty_q[g] != '0) && (credit_q >= MONEY_W'(price_q[g]));
   end

   assign credit       = credit_q;
   assign busy         = (state_q == VEND);
   assign deposit      = deposit_q;
   assign drop         = drop_q;
   assign change_valid = cv_q;
   assign change       = change_q;
   assign reject       = reject_q;
   assign err_sold_out = sold_q;
   assign err_funds    = funds_q;
   assign cfg_ack      = ack_q;

endmodule

// File: tb/tb_vend_datapath_p.sv
// Bench for vend_datapath_p: directed scenarios then random traffic, all
// checked each cycle against a transaction-level model of the vending rules.
module tb_vend_datapath_p;
   localparam int N = 32, SW = 5, MW = 13, PW = 10, QW = 5, MAXC = 5000;

   logic          clk = 1'b0, rst = 1'b0;
   logic          pay_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, cfg_we = 1'b0;
   logic [MW-1:0] payment = '0;
   logic [SW-1:0] select = '0, cfg_addr = '0;
   logic [PW-1:0] cfg_price = '0;
   logic [QW-1:0] cfg_qty = '0;
   logic [MW-1:0] credit, change;
   logic [N-1:0]  avail;
   logic [SW-1:0] drop;
   logic          busy, deposit, change_valid, reject, err_sold_out, err_funds, cfg_ack;

   vend_datapath_p dut (
      .clk(clk), .rst(rst), .pay_valid(pay_valid), .payment(payment),
      .sel_valid(sel_valid), .select(select), .cancel(cancel),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_price(cfg_price), .cfg_qty(cfg_qty),
      .credit(credit), .avail(avail), .busy(busy), .deposit(deposit), .drop(drop),
      .change_valid(change_valid), .change(change), .reject(reject),
      .err_sold_out(err_sold_out), .err_funds(err_funds), .cfg_ack(cfg_ack)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: credit, table contents and a pending-vend slot (-1 = none).
   int m_credit, m_pend, m_price[N], m_qty[N];
   int e_change, e_drop, e_dep, e_cv, e_rej, e_so, e_ef, e_ack;

   function automatic void model_step();
      int s;
      e_dep = 0; e_cv = 0; e_rej = 0; e_so = 0; e_ef = 0; e_ack = 0;
      if (rst) begin
         m_credit = 0; m_pend = -1; e_change = 0; e_drop = 0;
         for (int i = 0; i < N; i++) begin m_price[i] = 0; m_qty[i] = 0; end
         return;
      end
      if (m_pend >= 0) begin
         s = m_pend; m_pend = -1; e_rej = int'(pay_valid);
         if (s >= N || m_qty[s] == 0) e_so = 1;
         else if (m_credit < m_price[s]) e_ef = 1;
         else begin
            e_dep = 1; e_drop = s; m_qty[s]--; e_change = m_credit - m_price[s];
            e_cv = 1; m_credit = 0;
         end
         return;
      end
      if (cfg_we && m_credit == 0 && int'(cfg_addr) < N) begin
         m_price[cfg_addr] = int'(cfg_price); m_qty[cfg_addr] = int'(cfg_qty); e_ack = 1;
      end
      if (cancel) begin
         e_rej = int'(pay_valid);
         if (m_credit > 0) begin e_change = m_credit; e_cv = 1; m_credit = 0; end
      end else if (sel_valid) begin
         e_rej = int'(pay_valid);
         if (m_credit > 0) m_pend = int'(select);
      end else if (pay_valid && payment != 0) begin
         if (m_credit + int'(payment) <= MAXC) m_credit += int'(payment);
         else e_rej = 1;
      end
   endfunction

   // One clock: update model from current inputs, sample DUT after the edge, drop strobes.
   task automatic tick();
      logic [N-1:0] ea;
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) ea[i] = (m_qty[i] > 0) && (m_credit >= m_price[i]);
      chk("credit", 64'(credit), 64'(m_credit));
      chk("avail", 64'(avail), 64'(ea));
      chk("busy", 64'(busy), 64'(m_pend >= 0));
      chk("deposit", 64'(deposit), 64'(e_dep));
      chk("drop", 64'(drop), 64'(e_drop));
      chk("change_valid", 64'(change_valid), 64'(e_cv));
      chk("change", 64'(change), 64'(e_change));
      chk("reject", 64'(reject), 64'(e_rej));
      chk("err_sold_out", 64'(err_sold_out), 64'(e_so));
      chk("err_funds", 64'(err_funds), 64'(e_ef));
      chk("cfg_ack", 64'(cfg_ack), 64'(e_ack));
      pay_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; cfg_we = 1'b0; rst = 1'b0;
   endtask

   task automatic pay(input int v);
      pay_valid = 1'b1; payment = MW'(v); tick();
   endtask

   task automatic sel(input int s);
      sel_valid = 1'b1; select = SW'(s); tick(); tick();
   endtask

   task automatic load(input int a, input int p, input int q);
      cfg_we = 1'b1; cfg_addr = SW'(a); cfg_price = PW'(p); cfg_qty = QW'(q); tick();
   endtask

   initial begin
      m_credit = 0; m_pend = -1;
      rst = 1'b1; tick(); rst = 1'b1; tick();
      // Basic vend with change.
      load(3, 150, 2); pay(100); pay(100); sel(3);
      // Exact-price vend, then sold out, then refund.
      pay(100); pay(50); sel(3);
      pay(100); pay(50); sel(3);
      cancel = 1'b1; tick();
      // Ceiling.
      pay(4900); pay(200); pay(100); pay(1);
      cancel = 1'b1; tick();
      // Insufficient funds then top-up.
      load(5, 150, 3); pay(100); sel(5); pay(50); sel(5);
      // Simultaneous requests, write attempt outside IDLE.
      pay(70);
      cancel = 1'b1; sel_valid = 1'b1; select = 5'd5; pay_valid = 1'b1; payment = 13'd20; tick();
      pay(10); load(5, 7, 9); cancel = 1'b1; tick();
      // Reset during VEND.
      load(3, 100, 2); pay(200); sel_valid = 1'b1; select = 5'd3; tick();
      rst = 1'b1; tick(); tick();
      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         pay_valid = ($urandom_range(0, 2) == 0);
         payment   = ($urandom_range(0, 9) == 0) ? MW'($urandom_range(0, 8191))
                                                 : MW'($urandom_range(0, 300));
         sel_valid = ($urandom_range(0, 4) == 0);
         select    = SW'($urandom_range(0, N - 1));
         cancel    = ($urandom_range(0, 14) == 0);
         cfg_we    = ($urandom_range(0, 5) == 0);
         cfg_addr  = SW'($urandom_range(0, N - 1));
         cfg_price = PW'($urandom_range(0, 300));
         cfg_qty   = QW'($urandom_range(0, 3));
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
